// File: rtl/relu_backward_if.sv
// Memory handle shared by the FPU layer blocks: one tensor region plus a
// single-outstanding request/done handshake. The layer block is the master,
// the memory port is the slave.
interface mem_handle;
  logic [31:0] ptr;
  logic [31:0] region_begin;
  logic [31:0] region_end;
  logic [31:0] data_store;
  logic [31:0] data_load;
  logic        r_en;
  logic        w_en;
  logic        avail;
  logic        write_through;
  logic        done;

  modport master (
    output ptr, r_en, w_en, avail, data_store, write_through,
    input  region_begin, region_end, done, data_load
  );

  modport slave (
    input  ptr, r_en, w_en, avail, data_store, write_through,
    output region_begin, region_end, done, data_load
  );
endinterface

// File: rtl/relu_backward.sv
// ReLU backward pass: dx = dy where the forward input x is a positive non-zero
// fp32 pattern, +0.0 elsewhere. The tensor header of x is validated against
// the header of dy and copied to the output before the element loop, which is
// bounded by the output region alone.
module relu_backward #(
  parameter int MAX_DIMS = 4
) (
  input  logic      clk,
  input  logic      rst_l,
  mem_handle.master a,
  mem_handle.master b,
  mem_handle.master c,
  mem_handle.master d,
  input  logic      go,
  output logic      done,
  output logic      err
);

  // Header counter must hold values up to MAX_DIMS + 1 (dims plus ndims word).
  localparam int CW = $clog2(MAX_DIMS + 2);
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    WAIT,
    HDR_RD,
    HDR_CHK,
    HDR_WR,
    EL_RD,
    EL_WR,
    DONE
  } state_t;

  state_t      state;
  logic        issued;   // request of the current state has been raised
  logic        got_a;    // read on a completed in an earlier cycle
  logic        got_b;    // read on b completed in an earlier cycle
  logic [31:0] xa;       // last word read from a (x)
  logic [31:0] xb;       // last word read from b (dy)
  cnt_t        hdr_cnt;  // header words written so far
  cnt_t        hdr_len;  // ndims + 1, latched after word 0 is checked

  // Handshake completions: a request is finished on the edge where its
  // handle's done is sampled high while the request is still held.
  logic a_fire;
  logic b_fire;
  logic d_fire;
  logic reads_done;
  logic hdr_bad;
  logic x_pos;
  logic [31:0] dx;
  logic d_at_end;
  logic d_last;

  assign a_fire     = a.r_en & a.done;
  assign b_fire     = b.r_en & b.done;
  assign d_fire     = d.w_en & d.done;
  assign reads_done = (got_a | a_fire) & (got_b | b_fire);

  // Word 0 carries ndims and gets the range check; every word must match dy's.
  assign hdr_bad = (hdr_cnt == '0)
                 ? ((xa == 32'd0) || (xa > 32'(MAX_DIMS)) || (xa != xb))
                 : (xa != xb);

  // Pure bit test, no FPU: sign clear and magnitude non-zero passes dy.
  // Denormals, +Inf and positive NaN therefore pass; +-0 and negatives give 0.
  assign x_pos = ~xa[31] & (|xa[30:0]);
  assign dx    = x_pos ? xb : 32'h0;

  assign d_at_end = (d.ptr == d.region_end);
  assign d_last   = (d.ptr == d.region_end - 32'd1);

  // Handle directions that this block never uses are tied off.
  assign a.w_en          = 1'b0;
  assign a.data_store    = 32'h0;
  assign a.write_through = 1'b0;
  assign b.w_en          = 1'b0;
  assign b.data_store    = 32'h0;
  assign b.write_through = 1'b0;
  assign d.r_en          = 1'b0;

  // Handle c is present for port compatibility only.
  assign c.ptr           = 32'h0;
  assign c.r_en          = 1'b0;
  assign c.w_en          = 1'b0;
  assign c.avail         = 1'b0;
  assign c.data_store    = 32'h0;
  assign c.write_through = 1'b0;

  // Inputs with no consumer, gathered so the intent is explicit.
  logic unused_ok;
  assign unused_ok = ^{a.region_end, b.region_end, c.region_begin, c.region_end,
                       c.done, c.data_load, d.data_load};

  // Controller: handshake completion bookkeeping followed by the state machine.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= WAIT;
      done         <= 1'b0;
      err          <= 1'b0;
      issued       <= 1'b0;
      got_a        <= 1'b0;
      got_b        <= 1'b0;
      xa           <= 32'h0;
      xb           <= 32'h0;
      hdr_cnt      <= '0;
      hdr_len      <= '0;
      a.ptr        <= 32'h0;
      a.r_en       <= 1'b0;
      a.avail      <= 1'b0;
      b.ptr        <= 32'h0;
      b.r_en       <= 1'b0;
      b.avail      <= 1'b0;
      d.ptr        <= 32'h0;
      d.w_en       <= 1'b0;
      d.avail      <= 1'b0;
      d.data_store <= 32'h0;
      d.write_through <= 1'b0;
    end else begin
      // Completions are handled independently of the state so a and b may
      // finish in either order or together.
      if (a_fire) begin
        a.r_en  <= 1'b0;
        a.avail <= 1'b0;
        a.ptr   <= a.ptr + 32'd1;
        xa      <= a.data_load;
        got_a   <= 1'b1;
      end
      if (b_fire) begin
        b.r_en  <= 1'b0;
        b.avail <= 1'b0;
        b.ptr   <= b.ptr + 32'd1;
        xb      <= b.data_load;
        got_b   <= 1'b1;
      end
      if (d_fire) begin
        d.w_en          <= 1'b0;
        d.avail         <= 1'b0;
        d.write_through <= 1'b0;
        d.ptr           <= d.ptr + 32'd1;
      end

      // NOTE: when two non-blocking assignments to the same variable run on
      // one edge the later one wins, so the state arms below may override
      // got_a/got_b set above when both reads finish together.
      case (state)
        WAIT: begin
          if (go) begin
            a.ptr   <= a.region_begin;
            b.ptr   <= b.region_begin;
            d.ptr   <= d.region_begin;
            err     <= 1'b0;
            hdr_cnt <= '0;
            issued  <= 1'b0;
            got_a   <= 1'b0;
            got_b   <= 1'b0;
            state   <= HDR_RD;
          end
        end

        HDR_RD: begin
          if (!issued) begin
            if (!a.done && !b.done) begin
              a.r_en  <= 1'b1;
              a.avail <= 1'b1;
              b.r_en  <= 1'b1;
              b.avail <= 1'b1;
              issued  <= 1'b1;
            end
          end else if (reads_done) begin
            issued <= 1'b0;
            got_a  <= 1'b0;
            got_b  <= 1'b0;
            state  <= HDR_CHK;
          end
        end

        HDR_CHK: begin
          if (hdr_bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (hdr_cnt == '0) begin
              hdr_len <= xa[CW-1:0] + cnt_t'(1);
            end
            state <= HDR_WR;
          end
        end

        HDR_WR: begin
          if (!issued) begin
            if (!d.done) begin
              d.w_en       <= 1'b1;
              d.avail      <= 1'b1;
              d.data_store <= xa;
              issued       <= 1'b1;
            end
          end else if (d_fire) begin
            issued  <= 1'b0;
            hdr_cnt <= hdr_cnt + cnt_t'(1);
            state   <= (hdr_cnt + cnt_t'(1) == hdr_len) ? EL_RD : HDR_RD;
          end
        end

        EL_RD: begin
          if (!issued) begin
            if (d_at_end) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (!a.done && !b.done) begin
              a.r_en  <= 1'b1;
              a.avail <= 1'b1;
              b.r_en  <= 1'b1;
              b.avail <= 1'b1;
              issued  <= 1'b1;
            end
          end else if (reads_done) begin
            issued <= 1'b0;
            got_a  <= 1'b0;
            got_b  <= 1'b0;
            state  <= EL_WR;
          end
        end

        EL_WR: begin
          if (!issued) begin
            if (!d.done) begin
              d.w_en          <= 1'b1;
              d.avail         <= 1'b1;
              d.data_store    <= dx;
              d.write_through <= d_last;
              issued          <= 1'b1;
            end
          end else if (d_fire) begin
            issued <= 1'b0;
            state  <= EL_RD;
          end
        end

        DONE: begin
          if (!go) begin
            done  <= 1'b0;
            state <= WAIT;
          end
        end

        default: begin
          done  <= 1'b0;
          state <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// Self-checking bench for relu_backward: table vectors, hand-written corner
// sequences and randomized tensors checked against a behavioural model.
module tb_relu_backward;

  localparam int MAXD   = 4;
  localparam int A_BASE = 3;
  localparam int B_BASE = 37;
  localparam int D_BASE = 71;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wt;
  } wr_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] dy;
    logic [31:0] dx;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  logic go    = 1'b0;
  logic done;
  logic err;

  mem_handle ha ();
  mem_handle hb ();
  mem_handle hc ();
  mem_handle hd ();

  relu_backward #(.MAX_DIMS(MAXD)) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .a    (ha),
    .b    (hb),
    .c    (hc),
    .d    (hd),
    .go   (go),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  logic [31:0] mem_a [128];
  logic [31:0] mem_b [128];
  logic [31:0] a_end = 32'h0;
  logic [31:0] b_end = 32'h0;
  logic [31:0] d_end = 32'h0;
  int lat_a = 1;
  int lat_b = 1;
  int lat_d = 1;
  int cnt_a;
  int cnt_b;
  int cnt_d;
  int acc = 0;
  wr_t wr_q[$];

  // Latency L = cycles from request visible to the edge that samples done.
  assign ha.region_begin = 32'(A_BASE);
  assign ha.region_end   = a_end;
  assign ha.data_load    = mem_a[ha.ptr[6:0]];
  assign ha.done         = ha.r_en && ha.avail && (cnt_a >= lat_a - 1);
  assign hb.region_begin = 32'(B_BASE);
  assign hb.region_end   = b_end;
  assign hb.data_load    = mem_b[hb.ptr[6:0]];
  assign hb.done         = hb.r_en && hb.avail && (cnt_b >= lat_b - 1);
  assign hd.region_begin = 32'(D_BASE);
  assign hd.region_end   = d_end;
  assign hd.data_load    = 32'h0;
  assign hd.done         = hd.w_en && hd.avail && (cnt_d >= lat_d - 1);
  assign hc.region_begin = 32'h0;
  assign hc.region_end   = 32'h0;
  assign hc.data_load    = 32'h0;
  assign hc.done         = 1'b0;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_a <= 0;
      cnt_b <= 0;
      cnt_d <= 0;
    end else begin
      cnt_a <= (ha.r_en && ha.avail && !ha.done) ? cnt_a + 1 : 0;
      cnt_b <= (hb.r_en && hb.avail && !hb.done) ? cnt_b + 1 : 0;
      cnt_d <= (hd.w_en && hd.avail && !hd.done) ? cnt_d + 1 : 0;
    end
  end

  always @(posedge clk) begin
    acc <= acc + int'(ha.r_en && ha.done) + int'(hb.r_en && hb.done)
               + int'(hd.w_en && hd.done);
    if (hd.w_en && hd.avail && hd.done)
      wr_q.push_back(wr_t'{addr: hd.ptr, data: hd.data_store, wt: hd.write_through});
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ta [32];
  logic [31:0] tv [32];
  wr_t  exp_q[$];
  logic exp_err;
  int   exp_reads;
  int   exp_hdr;
  int   exp_nel;
  int   run_start;

  task automatic build_model(input int d_len);
    int n;
    logic [31:0] x;
    logic [31:0] dy;
    exp_q.delete();
    exp_err = 1'b0;
    exp_hdr = 0;
    exp_nel = 0;
    n = int'(ta[0]);
    if (ta[0] == 32'd0 || ta[0] > 32'(MAXD) || ta[0] != tv[0]) begin
      exp_err   = 1'b1;
      exp_reads = 1;
      return;
    end
    for (int k = 0; k <= n; k++) begin
      if (ta[k] != tv[k]) begin
        exp_err   = 1'b1;
        exp_reads = k + 1;
        return;
      end
      exp_q.push_back(wr_t'{addr: 32'(D_BASE + k), data: ta[k], wt: 1'b0});
    end
    exp_hdr = n + 1;
    exp_nel = d_len - exp_hdr;
    for (int e = 0; e < exp_nel; e++) begin
      x  = ta[exp_hdr + e];
      dy = tv[exp_hdr + e];
      exp_q.push_back(wr_t'{addr: 32'(D_BASE + exp_hdr + e),
                            data: (x != 32'd0 && x < 32'h8000_0000) ? dy : 32'h0,
                            wt:   (e == exp_nel - 1)});
    end
    exp_reads = exp_hdr + exp_nel;
  endtask

  // Loads the tensors, launches the block and checks every observable result.
  task automatic run_tensor(input string tag, input int d_len, input int hold, input bit early);
    int n;
    int m;
    int acc0;
    int idx;
    bit seen;
    for (int i = 0; i < 32; i++) begin
      mem_a[A_BASE + i] = ta[i];
      mem_b[B_BASE + i] = tv[i];
    end
    a_end = 32'(A_BASE + 32);
    b_end = 32'(B_BASE + 32);
    d_end = 32'(D_BASE + d_len);
    build_model(d_len);
    run_start = wr_q.size();
    @(negedge clk);
    go   = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (early) go = 1'b0;
      seen = done;
    end
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " err"}, 64'(err), 64'(exp_err));
    if (!exp_err) begin
      m = (lat_a > lat_b) ? lat_a : lat_b;
      check({tag, " cycles"}, 64'(n),
            64'(exp_hdr * (m + lat_d + 3) + exp_nel * (m + lat_d + 2) + 2));
    end
    acc0 = acc;
    repeat (hold) begin
      @(negedge clk);
      check({tag, " hold_done"}, 64'(done), 64'd1);
      check({tag, " hold_idle"}, 64'({ha.r_en, hb.r_en, hd.w_en}), 64'd0);
    end
    if (hold > 0) check({tag, " hold_no_access"}, 64'(acc), 64'(acc0));
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " exit_done"}, 64'(done), 64'd0);
    check({tag, " write_count"}, 64'(wr_q.size() - run_start), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      idx = run_start + i;
      check({tag, " wr_addr"}, (idx < wr_q.size()) ? 64'(wr_q[idx].addr) : 64'hFFFF_FFFF_0000_0000,
            64'(exp_q[i].addr));
      check({tag, " wr_data"}, (idx < wr_q.size()) ? 64'(wr_q[idx].data) : 64'hFFFF_FFFF_0000_0000,
            64'(exp_q[i].data));
      check({tag, " wr_through"}, (idx < wr_q.size()) ? 64'(wr_q[idx].wt) : 64'hFFFF_FFFF_0000_0000,
            64'(exp_q[i].wt));
    end
    check({tag, " a_ptr"}, 64'(ha.ptr), 64'(A_BASE + exp_reads));
    check({tag, " b_ptr"}, 64'(hb.ptr), 64'(B_BASE + exp_reads));
    check({tag, " d_ptr"}, 64'(hd.ptr), 64'(D_BASE + exp_q.size()));
  endtask

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(1, 255));
      3:       return {1'b1, r[30:0]};
      default: return {1'b0, r[30:0]};
    endcase
  endfunction

  // Random tensor of nd dims; returns the d region length.
  task automatic make_tensor(input int nd, input int dmax, output int d_len);
    int prod;
    prod  = 1;
    ta[0] = 32'(nd);
    for (int k = 1; k <= nd; k++) begin
      ta[k] = 32'($urandom_range(1, dmax));
      prod  = prod * int'(ta[k]);
    end
    for (int k = 0; k <= nd; k++) tv[k] = ta[k];
    for (int e = 0; e < prod; e++) begin
      ta[nd + 1 + e] = rand_x();
      tv[nd + 1 + e] = $urandom;
    end
    d_len = nd + 1 + prod;
  endtask

  task automatic set_hdr(input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] b0, input logic [31:0] b1);
    for (int i = 0; i < 32; i++) begin
      ta[i] = 32'd1;
      tv[i] = 32'd1;
    end
    ta[0] = a0;
    ta[1] = a1;
    tv[0] = b0;
    tv[1] = b1;
  endtask

  vec_t tbl [9];

  initial begin
    int dl;
    int lo;
    int cnt;
    int n;
    bit hit;

    tbl[0] = '{x: 32'h3F80_0000, dy: 32'h3F00_0000, dx: 32'h3F00_0000};
    tbl[1] = '{x: 32'hC000_0000, dy: 32'h3F00_0000, dx: 32'h0000_0000};
    tbl[2] = '{x: 32'h0000_0000, dy: 32'h3F00_0000, dx: 32'h0000_0000};
    tbl[3] = '{x: 32'h4060_0000, dy: 32'hBF80_0000, dx: 32'hBF80_0000};
    tbl[4] = '{x: 32'h8000_0000, dy: 32'h4000_0000, dx: 32'h0000_0000};
    tbl[5] = '{x: 32'h0000_0001, dy: 32'h4000_0000, dx: 32'h4000_0000};
    tbl[6] = '{x: 32'h7F80_0000, dy: 32'h4000_0000, dx: 32'h4000_0000};
    tbl[7] = '{x: 32'h7FC0_0000, dy: 32'h4000_0000, dx: 32'h4000_0000};
    tbl[8] = '{x: 32'hFF80_0000, dy: 32'h4000_0000, dx: 32'h0000_0000};

    // Reset state.
    #12;
    check("rst_flags", 64'({done, err}), 64'd0);
    check("rst_req", 64'({ha.r_en, ha.avail, hb.r_en, hb.avail, hd.w_en, hd.avail,
                          hd.write_through}), 64'd0);
    check("rst_ptrs", {ha.ptr, hd.ptr}, 64'd0);
    check("rst_c", 64'({hc.r_en, hc.w_en, hc.avail, hc.write_through}) | 64'(hc.ptr), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // Table vectors: basic 1-D case, then the special values.
    for (int g = 0; g < 2; g++) begin
      lo  = (g == 0) ? 0 : 4;
      cnt = (g == 0) ? 4 : 5;
      ta[0] = 32'd1;
      ta[1] = 32'(cnt);
      tv[0] = 32'd1;
      tv[1] = 32'(cnt);
      for (int i = 0; i < cnt; i++) begin
        ta[2 + i] = tbl[lo + i].x;
        tv[2 + i] = tbl[lo + i].dy;
      end
      run_tensor((g == 0) ? "basic" : "special", cnt + 2, 0, 1'b0);
      for (int i = 0; i < cnt; i++) begin
        n = run_start + 2 + i;
        check("tbl_dx", (n < wr_q.size()) ? 64'(wr_q[n].data) : 64'hFFFF_FFFF_0000_0000,
              64'(tbl[lo + i].dx));
      end
    end

    // Skewed latencies, 2-D header {2,2,3}.
    lat_a = 1;
    lat_b = 5;
    lat_d = 3;
    ta[0] = 32'd2; ta[1] = 32'd2; ta[2] = 32'd3;
    for (int k = 0; k < 3; k++) tv[k] = ta[k];
    for (int e = 0; e < 6; e++) begin
      ta[3 + e] = rand_x();
      tv[3 + e] = $urandom;
    end
    run_tensor("skew", 9, 0, 1'b0);

    // Header errors.
    lat_a = 2;
    lat_b = 1;
    lat_d = 2;
    set_hdr(32'd0, 32'd4, 32'd0, 32'd4);
    run_tensor("err_ndims0", 6, 0, 1'b0);
    set_hdr(32'd5, 32'd1, 32'd5, 32'd1);
    run_tensor("err_ndims5", 8, 0, 1'b0);
    set_hdr(32'd1, 32'd4, 32'd1, 32'd5);
    run_tensor("err_dim", 6, 0, 1'b0);
    set_hdr(32'd2, 32'd4, 32'd1, 32'd4);
    run_tensor("err_ndims_mismatch", 6, 0, 1'b0);

    // Empty data region.
    set_hdr(32'd1, 32'd0, 32'd1, 32'd0);
    run_tensor("empty", 2, 0, 1'b0);

    // Mid-run reset during an element write, then a full rerun.
    lat_a = 2;
    lat_b = 3;
    lat_d = 4;
    ta[0] = 32'd2; ta[1] = 32'd2; ta[2] = 32'd3;
    for (int k = 0; k < 3; k++) tv[k] = ta[k];
    for (int e = 0; e < 6; e++) begin
      ta[3 + e] = rand_x();
      tv[3 + e] = $urandom;
    end
    for (int i = 0; i < 32; i++) begin
      mem_a[A_BASE + i] = ta[i];
      mem_b[B_BASE + i] = tv[i];
    end
    d_end = 32'(D_BASE + 9);
    @(negedge clk);
    go  = 1'b1;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      hit = hd.w_en && (hd.ptr >= 32'(D_BASE + 4));
    end
    check("midrst_reached_el_wr", 64'(hit), 64'd1);
    @(negedge clk);
    rst_l = 1'b0;
    go    = 1'b0;
    #1;
    check("midrst_flags", 64'({done, err, ha.r_en, ha.avail, hb.r_en, hb.avail,
                               hd.w_en, hd.avail, hd.write_through}), 64'd0);
    check("midrst_ptrs", {ha.ptr, hd.ptr}, 64'd0);
    check("midrst_store", 64'(hd.data_store) | 64'(hb.ptr), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;
    run_tensor("rerun", 9, 0, 1'b0);

    // DONE held with go high, then released.
    lat_a = 1;
    lat_b = 2;
    lat_d = 1;
    make_tensor(1, 4, dl);
    run_tensor("hold", dl, 10, 1'b0);

    // Randomized tensors, one with go dropped right after launch.
    for (int t = 0; t < 12; t++) begin
      lat_a = $urandom_range(1, 4);
      lat_b = $urandom_range(1, 4);
      lat_d = $urandom_range(1, 4);
      n = $urandom_range(1, MAXD);
      make_tensor(n, (n <= 2) ? 4 : 2, dl);
      run_tensor((t == 5) ? "rand_early_go" : "rand", dl, 0, (t == 5));
    end

    check("c_idle", 64'({hc.r_en, hc.w_en, hc.avail}) | 64'(hc.ptr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
